// File: rtl/instr_fetch_mem.sv
// Clocked instruction memory with a boot-load port, valid/ready fetch handshake,
// 1-cycle registered read latency and a 2-entry in-order response buffer.
module instr_fetch_mem #(
  parameter int              WIDTH      = 24,
  parameter int              DEPTH      = 1024,
  parameter int              AW         = 24,
  parameter int              ADDR_SHIFT = 0,
  parameter int              BOOT_LOAD  = 1,
  parameter logic [WIDTH-1:0] NOP       = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_done,
  output logic             booting,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_instr,
  output logic [AW-1:0]    rsp_addr,
  output logic             rsp_err
);

  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW+31:0] DEPTH_W = (AW+32)'(DEPTH);

  typedef enum logic [0:0] {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [1:0]       cnt_r;
  logic [WIDTH-1:0] tail_instr_r;
  logic [AW-1:0]    tail_addr_r;
  logic             tail_err_r;

  logic [AW-1:0]    load_idx_s;
  logic [AW-1:0]    req_idx_s;
  logic             load_ok_s;
  logic             req_ok_s;
  logic [WIDTH-1:0] rd_instr_s;
  logic             rd_err_s;
  logic             accept_s;
  logic             pop_s;

  function automatic logic [AW-1:0] to_index(input logic [AW-1:0] a);
    return a >> ADDR_SHIFT;
  endfunction

  function automatic logic in_range(input logic [AW-1:0] idx);
    return ({32'd0, idx} < DEPTH_W);
  endfunction

  assign load_idx_s = to_index(load_addr);
  assign req_idx_s  = to_index(req_addr);
  assign load_ok_s  = in_range(load_idx_s);
  assign req_ok_s   = in_range(req_idx_s);

  assign booting   = (state_r == S_BOOT);
  assign rsp_valid = (cnt_r != 2'd0);
  assign req_ready = (state_r == S_RUN) && !flush && (cnt_r < 2'd2);
  assign accept_s  = req_valid && req_ready;
  assign pop_s     = rsp_valid && rsp_ready;

  // Memory array: written only while booting, never cleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n && (state_r == S_BOOT) && load_en && load_ok_s) begin
      mem_r[load_idx_s[MW-1:0]] <= load_data;
    end
  end

  // Read data for the request being accepted this cycle, NOP when out of range.
  always_comb begin
    rd_instr_s = NOP;
    rd_err_s   = 1'b1;
    if (req_ok_s) begin
      rd_instr_s = mem_r[req_idx_s[MW-1:0]];
      rd_err_s   = 1'b0;
    end else begin
      rd_instr_s = NOP;
      rd_err_s   = 1'b1;
    end
  end

  // Boot/run state, response buffer (head drives the outputs) and outstanding count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= (BOOT_LOAD != 0) ? S_BOOT : S_RUN;
      cnt_r        <= 2'd0;
      rsp_instr    <= '0;
      rsp_addr     <= '0;
      rsp_err      <= 1'b0;
      tail_instr_r <= '0;
      tail_addr_r  <= '0;
      tail_err_r   <= 1'b0;
    end else begin
      case (state_r)
        S_BOOT:  state_r <= load_done ? S_RUN : S_BOOT;
        S_RUN:   state_r <= S_RUN;
        default: state_r <= S_BOOT;
      endcase

      if (flush && (state_r == S_RUN)) begin
        cnt_r <= 2'd0;
      end else begin
        case ({accept_s, pop_s})
          2'b10: begin
            if (cnt_r == 2'd0) begin
              rsp_instr <= rd_instr_s;
              rsp_addr  <= req_addr;
              rsp_err   <= rd_err_s;
            end else begin
              tail_instr_r <= rd_instr_s;
              tail_addr_r  <= req_addr;
              tail_err_r   <= rd_err_s;
            end
            cnt_r <= cnt_r + 2'd1;
          end
          2'b01: begin
            rsp_instr <= tail_instr_r;
            rsp_addr  <= tail_addr_r;
            rsp_err   <= tail_err_r;
            cnt_r     <= cnt_r - 2'd1;
          end
          2'b11: begin
            // Head leaves while a new entry arrives; it lands wherever the new head is.
            if (cnt_r == 2'd1) begin
              rsp_instr <= rd_instr_s;
              rsp_addr  <= req_addr;
              rsp_err   <= rd_err_s;
            end else begin
              rsp_instr    <= tail_instr_r;
              rsp_addr     <= tail_addr_r;
              rsp_err      <= tail_err_r;
              tail_instr_r <= rd_instr_s;
              tail_addr_r  <= req_addr;
              tail_err_r   <= rd_err_s;
            end
            cnt_r <= cnt_r;
          end
          default: cnt_r <= cnt_r;
        endcase
      end
    end
  end

endmodule

// File: doc/instr_fetch_mem.md
Name: instr_fetch_mem

Overview:
Parametrised, clocked successor to the team's asynchronous instruction ROM. It holds the program in a DEPTH x WIDTH array and can be loaded through a boot port after reset. Fetch requests and responses each use a valid/ready handshake, with registered 1-cycle read latency, a 2-entry in-order response buffer, a flush input and out-of-range error flagging. It sits between the PC/fetch stage and decode.

Parameters:
WIDTH, 24, instruction width in bits
DEPTH, 1024, number of instruction words
AW, 24, request/load address width
ADDR_SHIFT, 0, index = addr >> ADDR_SHIFT (0 = word addressing, 2 = byte addressing with 4-byte stride)
BOOT_LOAD, 1, 1 = start in BOOT after reset; 0 = go straight to RUN
NOP, 0, WIDTH-bit value returned on out-of-range fetch

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk
load_en  in  1  boot write strobe
load_addr  in  AW  boot write address (ADDR_SHIFT applied)
load_data  in  WIDTH  boot write data
load_done  in  1  ends BOOT
booting  out  1  high while in BOOT
flush  in  1  discard all outstanding fetches
req_valid  in  1  fetch request valid
req_ready  out  1  fetch request accepted when valid&&ready
req_addr  in  AW  fetch address
rsp_valid  out  1  response at buffer head valid
rsp_ready  in  1  consumer accepts response
rsp_instr  out  WIDTH  fetched instruction
rsp_addr  out  AW  request address echoed with the response
rsp_err  out  1  index >= DEPTH for this response

Behaviour:
- Reset, when rst_n=0 at an edge:
  - state = BOOT if BOOT_LOAD else RUN; booting = BOOT_LOAD.
  - req_ready=0, rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0; in-flight read and buffer cleared; outstanding count cnt=0.
  - Memory array is NOT reset; contents survive reset.
- FSM BOOT:
  - req_ready=0.
  - load_en=1 writes load_data at index(load_addr) at the edge. Writes with index >= DEPTH are dropped.
  - load_done=1 moves to RUN at the next edge. If load_en and load_done arrive in the same cycle, the write completes and the transition still occurs.
- FSM RUN:
  - load_en and load_done are ignored; RUN -> BOOT only via reset.
- req_ready = (state==RUN) && !flush && (cnt < 2). cnt counts accepted responses not yet consumed. There is no combinational path from rsp_ready.
- Accept at edge T: the array is read synchronously; the response enters the buffer and is visible at T+1 with rsp_addr = req_addr.
  - index >= DEPTH: rsp_instr = NOP, rsp_err=1.
  - Otherwise rsp_err=0.
- cnt update per edge: cnt += accept; cnt -= (rsp_valid && rsp_ready); both may happen in the same cycle. Back-to-back accept with rsp_ready=1 sustains 1 fetch/cycle.
- Buffer: 2-entry FIFO, strictly in order.
  - rsp_valid = buffer non-empty; head outputs held stable while rsp_valid && !rsp_ready.
  - The buffer cannot overflow because cnt <= 2.
- flush=1 at edge T (RUN):
  - Buffer and in-flight read are discarded; cnt=0; no request accepted at T.
  - rsp_valid=0 after T; requests resume at T+1.
- flush in BOOT has no effect. Reset takes priority over flush.
- Reset mid-operation drops all outstanding responses; no response for a pre-reset request ever appears.
- Simultaneous memory write and read cannot occur, because writes happen only in BOOT and reads only in RUN.

Test Plan:
- Boot and stream: load 0x000011@0, 0x000022@1, 0x000033@2, pulse load_done. Then req addr 0,1,2 on consecutive cycles with rsp_ready=1 -> rsp_valid on 3 consecutive cycles starting 1 cycle after first accept, data 0x11,0x22,0x33, rsp_addr 0,1,2, rsp_err=0, req_ready stays 1.
- Backpressure: rsp_ready=0, req_valid held for addr 0,1,2 -> exactly two accepts, then req_ready=0. rsp_instr/rsp_addr stay at 0x11/0 stable. After rsp_ready=1 -> 0x11, 0x22, 0x33 delivered in order with no loss or duplicate.
- Out-of-range: req addr 1024 (DEPTH=1024) -> rsp_err=1, rsp_instr=NOP=0, rsp_addr=1024. Next req addr 1 -> 0x22, rsp_err=0.
- Flush: two outstanding (rsp_ready=0), assert flush 1 cycle -> rsp_valid=0 next cycle, req_ready=0 during the flush cycle and 1 after. New req addr 2 -> 0x33.
- Reset and boot-port lockout:
  - In RUN, load_en writes 0xABCDEF@1 -> ignored; addr 1 still 0x22.
  - Pulse rst_n=0 mid-stream -> all outputs take reset values, booting=1, and no stale response appears.
  - load_done then fetch addr 1 -> 0x22, proving memory is retained through reset.
- ADDR_SHIFT=2 build: load via byte addresses 0,4,8 -> fetch byte addr 4 returns the word at index 1.
